branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised branch resolution stage for the custom 6502 core. Evaluates a
//  branch condition (eq/ne/lt/le/gt/ge/always, signed or unsigned), registers
//  the result behind a valid/ready handshake, computes next PC, flags
//  mispredicts against fetch's prediction, and owns a 2-bit saturating predictor
//  table that fetch reads combinationally. Sits between decode/ALU and fetch.
// PARAMETERS
//  DATA_W      8   operand width, >=1
//  PC_W        16  program counter width
//  PRED_DEPTH  16  predictor entries; power of 2, >=2; index = pc[log2(PRED_DEPTH)-1:0]
//  FALL_INC    2   fall-through PC increment (6502 relative branch length)
// PORTS
//  clk             in   1       rising-edge clock
//  rst             in   1       async reset, active-high
//  valid_in        in   1       branch request valid
//  ready_out       out  1       unit can accept request
//  cond_in         in   3       0 none,1 eq,2 ne,3 lt,4 le,5 gt,6 ge,7 always
//  signed_in       in   1       1: two's-complement compare; 0: unsigned
//  data1_in        in   DATA_W  left operand
//  data2_in        in   DATA_W  right operand
//  pc_in           in   PC_W    PC of branch instruction
//  target_in       in   PC_W    taken target
//  pred_taken_in   in   1       prediction fetch used for this branch
//  flush_in        in   1       kill the held result (older redirect)
//  valid_out       out  1       resolved result valid
//  ready_in        in   1       consumer accepts result
//  taken_out       out  1       branch resolved taken
//  next_pc_out     out  PC_W    taken ? target : pc+FALL_INC (mod 2^PC_W)
//  mispredict_out  out  1       valid_out && (taken_out != held pred_taken)
//  lookup_pc_in    in   PC_W    fetch predictor lookup address
//  lookup_taken_out out 1       counter[lookup index][1], combinational
// BEHAVIOUR
//  - Reset: valid_out=0, taken_out=0, next_pc_out=0, mispredict_out=0; all
//    counters = 2'b01 (weak not-taken); lookup_taken_out therefore 0.
//  - One output register stage; latency 1 cycle from input handshake.
//  - ready_out = !valid_out || ready_in (combinational, no bubble on stream).
//  - Capture when valid_in && ready_out: compare result, next PC, pred bit,
//    table index all registered; valid_out<=1. Else if ready_in: valid_out<=0.
//  - cond 0 never taken; cond 7 always taken regardless of operands.
//  - signed_in only affects lt/le/gt/ge; eq/ne identical in both modes.
//  - Predictor update on output handshake (valid_out && ready_in && !flush_in):
//    taken -> counter+1 saturating at 3; not taken -> counter-1 saturating at 0.
//  - Only cond 1-6 train the table; cond 0 and 7 do not update.
//  - Lookup same cycle as update to same index returns pre-update value.
//  - flush_in: valid_out<=0 next cycle, no table update, mispredict suppressed;
//    a simultaneous valid_in is NOT captured (ready_out forced 0 during flush).
//  - Next PC wraps: pc 16'hFFFF + 2 -> 16'h0001.
//  - Async reset mid-transfer drops held result; table reinitialised.
//  - Outputs stable while valid_out && !ready_in (backpressure hold).
// TESTING
//  1. eq, d1=d2=8'h5A, pred=0, ready_in=1 -> next cycle valid_out=1, taken=1,
//     mispredict=1, next_pc=target; entry goes 01->10, lookup_taken_out=1.
//  2. lt, d1=8'h80, d2=8'h01: signed -> taken; unsigned -> not taken,
//     next_pc=pc+2.
//  3. Back-to-back valid_in for 4 cycles, ready_in=0 on cycle 2 -> results held
//     stable, ready_out=0, no request lost or duplicated, in-order outputs.
//  4. Six taken branches same pc -> counter saturates at 3; three not-taken ->
//     0b00 after 3, lookup_taken_out falls to 0 after second.
//  5. flush_in with valid_out=1 and valid_in=1 -> valid_out=0, no capture,
//     counter unchanged; pc=16'hFFFF not-taken -> next_pc=16'h0001.
//  6. rst asserted asynchronously mid-stream -> valid_out=0 immediately, all
//     entries read back weak not-taken.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit_if
// Bundles every non-clock/reset signal of the branch resolution stage.
//   master : upstream side (decode/ALU request, consumer ready, fetch lookup)
//   slave  : the branch_resolve_unit itself
// Signals
//   valid_in/ready_out        request handshake (decode/ALU -> unit)
//   cond_in, signed_in        condition code and compare mode
//   data1_in, data2_in        operands
//   pc_in, target_in          branch PC and taken target
//   pred_taken_in             prediction fetch used for this branch
//   flush_in                  kill the held result
//   valid_out/ready_in        result handshake (unit -> consumer)
//   taken_out, next_pc_out    resolved direction and next PC
//   mispredict_out            resolved direction differs from prediction
//   lookup_pc_in/lookup_taken_out  fetch-side predictor read port
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds its payload stable while valid is high
// and ready is low, and ready may depend combinationally on the sink's state.
// ----------------------------------------------------------------------------
interface branch_resolve_unit_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 16
);
    logic              valid_in;
    logic              ready_out;
    logic [2:0]        cond_in;
    logic              signed_in;
    logic [DATA_W-1:0] data1_in;
    logic [DATA_W-1:0] data2_in;
    logic [PC_W-1:0]   pc_in;
    logic [PC_W-1:0]   target_in;
    logic              pred_taken_in;
    logic              flush_in;
    logic              valid_out;
    logic              ready_in;
    logic              taken_out;
    logic [PC_W-1:0]   next_pc_out;
    logic              mispredict_out;
    logic [PC_W-1:0]   lookup_pc_in;
    logic              lookup_taken_out;

    modport master (
        output valid_in, cond_in, signed_in, data1_in, data2_in, pc_in,
               target_in, pred_taken_in, flush_in, ready_in, lookup_pc_in,
        input  ready_out, valid_out, taken_out, next_pc_out, mispredict_out,
               lookup_taken_out
    );

    modport slave (
        input  valid_in, cond_in, signed_in, data1_in, data2_in, pc_in,
               target_in, pred_taken_in, flush_in, ready_in, lookup_pc_in,
        output ready_out, valid_out, taken_out, next_pc_out, mispredict_out,
               lookup_taken_out
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
// Resolves a branch condition, registers the result behind a valid/ready
// output stage (latency 1), computes the next PC, flags mispredicts and owns
// a table of 2-bit saturating counters that fetch reads combinationally.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bru  : branch_resolve_unit_if.slave (request, result and lookup signals)
// Condition codes: 0 none, 1 eq, 2 ne, 3 lt, 4 le, 5 gt, 6 ge, 7 always.
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 16,
    parameter int PRED_DEPTH = 16,
    parameter int FALL_INC   = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bru
);
    localparam int              IDX_W       = $clog2(PRED_DEPTH);
    localparam logic [PC_W-1:0] FALL_INC_PC = PC_W'(FALL_INC);

    logic              w_eq;
    logic              w_lt;
    logic              w_taken;
    logic              w_trains;
    logic              w_ready;
    logic              w_accept;
    logic              w_out_fire;
    logic              w_train_upd;
    logic [PC_W-1:0]   w_next_pc;
    logic [IDX_W-1:0]  w_lookup_idx;
    logic [1:0]        w_cnt_cur;
    logic [1:0]        w_cnt_next;

    logic              r_valid;
    logic              r_taken;
    logic              r_pred;
    logic              r_trains;
    logic [PC_W-1:0]   r_next_pc;
    logic [IDX_W-1:0]  r_idx;
    logic [1:0]        r_cnt [PRED_DEPTH];

    // Condition evaluation; le/gt/ge are derived from eq and lt so signedness
    // only has to be handled in one comparator.
    always_comb begin
        w_eq = (bru.data1_in == bru.data2_in);
        if (bru.signed_in) begin
            w_lt = ($signed(bru.data1_in) < $signed(bru.data2_in));
        end else begin
            w_lt = (bru.data1_in < bru.data2_in);
        end
        case (bru.cond_in)
            3'd1:    w_taken = w_eq;
            3'd2:    w_taken = !w_eq;
            3'd3:    w_taken = w_lt;
            3'd4:    w_taken = w_lt || w_eq;
            3'd5:    w_taken = !(w_lt || w_eq);
            3'd6:    w_taken = !w_lt;
            3'd7:    w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // Unconditional (7) and never-taken (0) carry no direction information,
    // so only real compares train the predictor.
    assign w_trains  = (bru.cond_in != 3'd0) && (bru.cond_in != 3'd7);
    assign w_next_pc = w_taken ? bru.target_in : (bru.pc_in + FALL_INC_PC);

    // A flush blocks capture so the killed slot is not refilled that cycle.
    assign w_ready     = !bru.flush_in && (!r_valid || bru.ready_in);
    assign w_accept    = bru.valid_in && w_ready;
    assign w_out_fire  = r_valid && bru.ready_in && !bru.flush_in;
    assign w_train_upd = w_out_fire && r_trains;

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_pred    <= 1'b0;
            r_trains  <= 1'b0;
            r_next_pc <= '0;
            r_idx     <= '0;
        end else begin
            if (w_accept) begin
                r_valid   <= 1'b1;
                r_taken   <= w_taken;
                r_pred    <= bru.pred_taken_in;
                r_trains  <= w_trains;
                r_next_pc <= w_next_pc;
                r_idx     <= bru.pc_in[IDX_W-1:0];
            end else if (bru.ready_in || bru.flush_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Saturating counter step for the entry of the result being retired.
    assign w_cnt_cur = r_cnt[r_idx];
    always_comb begin
        if (r_taken) begin
            w_cnt_next = (w_cnt_cur == 2'b11) ? 2'b11 : (w_cnt_cur + 2'b01);
        end else begin
            w_cnt_next = (w_cnt_cur == 2'b00) ? 2'b00 : (w_cnt_cur - 2'b01);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PRED_DEPTH; i++) begin
                r_cnt[i] <= 2'b01;
            end
        end else if (w_train_upd) begin
            r_cnt[r_idx] <= w_cnt_next;
        end
    end

    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is not visible until the following cycle.
    assign w_lookup_idx         = bru.lookup_pc_in[IDX_W-1:0];
    assign bru.lookup_taken_out = r_cnt[w_lookup_idx][1];

    assign bru.ready_out      = w_ready;
    assign bru.valid_out      = r_valid;
    assign bru.taken_out      = r_taken;
    assign bru.next_pc_out    = r_next_pc;
    assign bru.mispredict_out = r_valid && !bru.flush_in && (r_taken != r_pred);
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    localparam int EW = 23;  // {trains, idx[3:0], mispredict, taken, next_pc[15:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ref_cnt [16];
    logic [EW-1:0] exp_q [$];

    branch_resolve_unit_if #(.DATA_W(8), .PC_W(16)) bru ();

    branch_resolve_unit #(
        .DATA_W(8), .PC_W(16), .PRED_DEPTH(16), .FALL_INC(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bru (bru)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit ref_taken(int cond, bit sgn, int d1, int d2);
        int a;
        int b;
        bit t;
        a = d1;
        b = d2;
        if (sgn) begin
            if (a >= 128) a = a - 256;
            if (b >= 128) b = b - 256;
        end
        case (cond)
            0:       t = 1'b0;
            1:       t = (a == b);
            2:       t = (a != b);
            3:       t = (a < b);
            4:       t = (a <= b);
            5:       t = (a > b);
            6:       t = (a >= b);
            default: t = 1'b1;
        endcase
        return t;
    endfunction

    function automatic logic [15:0] ref_next_pc(int pc, int tgt, bit tk);
        int n;
        n = tk ? tgt : ((pc + 2) % 65536);
        return 16'(n);
    endfunction

    function automatic logic [EW-1:0] ref_entry(int cond, bit sgn, int d1, int d2,
                                                int pc, int tgt, bit pred);
        bit tk;
        bit tr;
        tk = ref_taken(cond, sgn, d1, d2);
        tr = (cond >= 1) && (cond <= 6);
        return {tr, 4'(pc % 16), (tk != pred), tk, ref_next_pc(pc, tgt, tk)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bru.valid_in      = 1'b0;
        bru.cond_in       = 3'd0;
        bru.signed_in     = 1'b0;
        bru.data1_in      = 8'h00;
        bru.data2_in      = 8'h00;
        bru.pc_in         = 16'h0000;
        bru.target_in     = 16'h0000;
        bru.pred_taken_in = 1'b0;
        bru.flush_in      = 1'b0;
        bru.ready_in      = 1'b1;
        bru.lookup_pc_in  = 16'h0000;
    endtask

    task automatic drive_req(input int v, input int cond, input int sgn, input int d1,
                             input int d2, input int pc, input int tgt, input int pred);
        bru.valid_in      = v[0];
        bru.cond_in       = 3'(cond);
        bru.signed_in     = sgn[0];
        bru.data1_in      = 8'(d1);
        bru.data2_in      = 8'(d2);
        bru.pc_in         = 16'(pc);
        bru.target_in     = 16'(tgt);
        bru.pred_taken_in = pred[0];
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bru.valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", bru.valid_out); end
        n_checks++; if (bru.taken_out !== 1'b0) begin n_errors++; $display("FAIL reset_taken got %b exp 0", bru.taken_out); end
        n_checks++; if (bru.next_pc_out !== 16'h0000) begin n_errors++; $display("FAIL reset_next_pc got %h exp 0000", bru.next_pc_out); end
        n_checks++; if (bru.mispredict_out !== 1'b0) begin n_errors++; $display("FAIL reset_mispredict got %b exp 0", bru.mispredict_out); end
        n_checks++; if (bru.ready_out !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", bru.ready_out); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bru.lookup_pc_in = 16'(i);
            #1;
            n_checks++; if (bru.lookup_taken_out !== 1'b0) begin n_errors++; $display("FAIL reset_lookup idx %0d got %b exp 0", i, bru.lookup_taken_out); end
        end
        tick();
    endtask

    task automatic test_eq_mispredict();
        logic [15:0] e_pc;
        bit e_tk;
        apply_reset();
        e_tk = ref_taken(1, 0, 'h5A, 'h5A);
        e_pc = ref_next_pc('h0203, 'h0250, e_tk);
        bru.lookup_pc_in = 16'h0203;
        drive_req(1, 1, 0, 'h5A, 'h5A, 'h0203, 'h0250, 0);
        tick();
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.valid_out !== 1'b1) begin n_errors++; $display("FAIL eq_valid got %b exp 1", bru.valid_out); end
        n_checks++; if (bru.taken_out !== e_tk) begin n_errors++; $display("FAIL eq_taken got %b exp %b", bru.taken_out, e_tk); end
        n_checks++; if (bru.mispredict_out !== 1'b1) begin n_errors++; $display("FAIL eq_mispredict got %b exp 1", bru.mispredict_out); end
        n_checks++; if (bru.next_pc_out !== e_pc) begin n_errors++; $display("FAIL eq_next_pc got %h exp %h", bru.next_pc_out, e_pc); end
        n_checks++; if (bru.lookup_taken_out !== 1'b0) begin n_errors++; $display("FAIL eq_lookup_pre got %b exp 0", bru.lookup_taken_out); end
        tick();
        n_checks++; if (bru.lookup_taken_out !== 1'b1) begin n_errors++; $display("FAIL eq_lookup_post got %b exp 1", bru.lookup_taken_out); end
        n_checks++; if (bru.valid_out !== 1'b0) begin n_errors++; $display("FAIL eq_valid_drop got %b exp 0", bru.valid_out); end
    endtask

    task automatic test_signed_lt();
        apply_reset();
        drive_req(1, 3, 1, 'h80, 'h01, 'h1004, 'h1100, 1);
        tick();
        drive_req(1, 3, 0, 'h80, 'h01, 'h1004, 'h1100, 1);
        #1;
        n_checks++; if (bru.taken_out !== ref_taken(3, 1, 'h80, 'h01)) begin n_errors++; $display("FAIL lt_signed_taken got %b exp 1", bru.taken_out); end
        n_checks++; if (bru.next_pc_out !== 16'h1100) begin n_errors++; $display("FAIL lt_signed_pc got %h exp 1100", bru.next_pc_out); end
        n_checks++; if (bru.mispredict_out !== 1'b0) begin n_errors++; $display("FAIL lt_signed_misp got %b exp 0", bru.mispredict_out); end
        tick();
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.taken_out !== ref_taken(3, 0, 'h80, 'h01)) begin n_errors++; $display("FAIL lt_unsigned_taken got %b exp 0", bru.taken_out); end
        n_checks++; if (bru.next_pc_out !== 16'h1006) begin n_errors++; $display("FAIL lt_unsigned_pc got %h exp 1006", bru.next_pc_out); end
        n_checks++; if (bru.mispredict_out !== 1'b1) begin n_errors++; $display("FAIL lt_unsigned_misp got %b exp 1", bru.mispredict_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cond_a [4];
        int sgn_a [4];
        int d1_a [4];
        int d2_a [4];
        int pc_a [4];
        int tgt_a [4];
        int pred_a [4];
        int sent;
        int got;
        bit exp_rdy;
        logic [EW-1:0] e;
        apply_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            cond_a[k] = $urandom_range(1, 6);
            sgn_a[k]  = $urandom_range(0, 1);
            d1_a[k]   = $urandom_range(0, 255);
            d2_a[k]   = $urandom_range(0, 255);
            pc_a[k]   = $urandom_range(0, 65535);
            tgt_a[k]  = $urandom_range(0, 65535);
            pred_a[k] = $urandom_range(0, 1);
        end
        sent = 0;
        got  = 0;
        for (int c = 0; c < 12 && got < 4; c++) begin
            bru.ready_in = (c != 2);
            if (sent < 4) drive_req(1, cond_a[sent], sgn_a[sent], d1_a[sent], d2_a[sent], pc_a[sent], tgt_a[sent], pred_a[sent]);
            else bru.valid_in = 1'b0;
            #1;
            exp_rdy = (exp_q.size() == 0) || bru.ready_in;
            n_checks++; if (bru.ready_out !== exp_rdy) begin n_errors++; $display("FAIL b2b_ready cyc %0d got %b exp %b", c, bru.ready_out, exp_rdy); end
            n_checks++; if (bru.valid_out !== (exp_q.size() != 0)) begin n_errors++; $display("FAIL b2b_valid cyc %0d got %b exp %b", c, bru.valid_out, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                n_checks++; if ({bru.taken_out, bru.next_pc_out} !== e[16:0]) begin n_errors++; $display("FAIL b2b_result cyc %0d got %h exp %h", c, {bru.taken_out, bru.next_pc_out}, e[16:0]); end
                if (bru.ready_in) begin
                    void'(exp_q.pop_front());
                    got++;
                end
            end
            if (bru.valid_in && exp_rdy) begin
                exp_q.push_back(ref_entry(cond_a[sent], sgn_a[sent][0], d1_a[sent], d2_a[sent], pc_a[sent], tgt_a[sent], pred_a[sent][0]));
                sent++;
            end
            tick();
        end
        bru.valid_in = 1'b0;
        bru.ready_in = 1'b1;
        n_checks++; if (got !== 4) begin n_errors++; $display("FAIL b2b_count got %0d exp 4", got); end
        tick();
        n_checks++; if (bru.valid_out !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got %b exp 0", bru.valid_out); end
    endtask

    task automatic test_saturation();
        int c;
        apply_reset();
        c = 1;
        bru.lookup_pc_in = 16'h0007;
        for (int k = 0; k < 13; k++) begin
            // 6 taken eq, 3 not-taken ne, 1 taken eq, 2 always, 1 not-taken ne
            if (k < 6 || k == 9) drive_req(1, 1, 0, 'h11, 'h11, 'h0007, 'h0100, 0);
            else if (k < 9 || k == 12) drive_req(1, 2, 0, 'h11, 'h11, 'h0007, 'h0100, 0);
            else drive_req(1, 7, 0, 'h11, 'h22, 'h0007, 'h0100, 0);
            tick();
            bru.valid_in = 1'b0;
            tick();
            if (k < 6 || k == 9) c = (c == 3) ? 3 : c + 1;
            else if (k < 9 || k == 12) c = (c == 0) ? 0 : c - 1;
            n_checks++; if (bru.lookup_taken_out !== (c >= 2)) begin n_errors++; $display("FAIL sat_lookup step %0d got %b exp %b", k, bru.lookup_taken_out, c >= 2); end
        end
    endtask

    task automatic test_flush_wrap();
        apply_reset();
        bru.ready_in = 1'b0;
        bru.lookup_pc_in = 16'h0009;
        drive_req(1, 1, 0, 'h42, 'h42, 'h0009, 'h0300, 0);
        tick();
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.mispredict_out !== 1'b1) begin n_errors++; $display("FAIL flush_pre_misp got %b exp 1", bru.mispredict_out); end
        bru.flush_in = 1'b1;
        bru.ready_in = 1'b1;
        drive_req(1, 1, 0, 'h42, 'h42, 'h0109, 'h0400, 0);
        #1;
        n_checks++; if (bru.ready_out !== 1'b0) begin n_errors++; $display("FAIL flush_ready got %b exp 0", bru.ready_out); end
        n_checks++; if (bru.mispredict_out !== 1'b0) begin n_errors++; $display("FAIL flush_misp got %b exp 0", bru.mispredict_out); end
        tick();
        bru.flush_in = 1'b0;
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.valid_out !== 1'b0) begin n_errors++; $display("FAIL flush_valid got %b exp 0", bru.valid_out); end
        n_checks++; if (bru.lookup_taken_out !== 1'b0) begin n_errors++; $display("FAIL flush_counter got %b exp 0", bru.lookup_taken_out); end
        drive_req(1, 2, 0, 'h33, 'h33, 'hFFFF, 'h1234, 0);
        tick();
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.taken_out !== 1'b0) begin n_errors++; $display("FAIL wrap_taken got %b exp 0", bru.taken_out); end
        n_checks++; if (bru.next_pc_out !== 16'h0001) begin n_errors++; $display("FAIL wrap_next_pc got %h exp 0001", bru.next_pc_out); end
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bru.lookup_pc_in = 16'h0002;
        for (int k = 0; k < 2; k++) begin
            drive_req(1, 1, 0, 'h05, 'h05, 'h0002, 'h0020, 1);
            tick();
            bru.valid_in = 1'b0;
            tick();
        end
        n_checks++; if (bru.lookup_taken_out !== 1'b1) begin n_errors++; $display("FAIL arst_trained got %b exp 1", bru.lookup_taken_out); end
        bru.ready_in = 1'b0;
        drive_req(1, 7, 0, 'h00, 'h00, 'h0002, 'hABCD, 0);
        tick();
        bru.valid_in = 1'b0;
        #1;
        n_checks++; if (bru.valid_out !== 1'b1) begin n_errors++; $display("FAIL arst_held got %b exp 1", bru.valid_out); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (bru.valid_out !== 1'b0) begin n_errors++; $display("FAIL arst_valid got %b exp 0", bru.valid_out); end
        n_checks++; if (bru.next_pc_out !== 16'h0000) begin n_errors++; $display("FAIL arst_next_pc got %h exp 0000", bru.next_pc_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bru.ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bru.lookup_pc_in = 16'(i);
            #1;
            n_checks++; if (bru.lookup_taken_out !== 1'b0) begin n_errors++; $display("FAIL arst_lookup idx %0d got %b exp 0", i, bru.lookup_taken_out); end
        end
        bru.lookup_pc_in = 16'h0002;
        drive_req(1, 1, 0, 'h05, 'h05, 'h0002, 'h0020, 1);
        tick();
        bru.valid_in = 1'b0;
        tick();
        n_checks++; if (bru.lookup_taken_out !== 1'b1) begin n_errors++; $display("FAIL arst_weak got %b exp 1", bru.lookup_taken_out); end
    endtask

    task automatic test_random();
        int cond, sgn, d1, d2, pc, tgt, pred, lpc;
        bit exp_valid;
        bit exp_rdy;
        logic [EW-1:0] e;
        int ix;
        apply_reset();
        for (int i = 0; i < 16; i++) ref_cnt[i] = 1;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            cond = $urandom_range(0, 7);
            sgn  = $urandom_range(0, 1);
            d1   = $urandom_range(0, 255);
            d2   = ($urandom_range(0, 3) == 0) ? d1 : $urandom_range(0, 255);
            pc   = $urandom_range(0, 65535);
            tgt  = $urandom_range(0, 65535);
            pred = $urandom_range(0, 1);
            lpc  = $urandom_range(0, 65535);
            drive_req(($urandom_range(0, 9) < 7) ? 1 : 0, cond, sgn, d1, d2, pc, tgt, pred);
            bru.flush_in     = ($urandom_range(0, 9) == 0);
            bru.ready_in     = ($urandom_range(0, 9) < 7);
            bru.lookup_pc_in = 16'(lpc);
            #1;
            exp_valid = (exp_q.size() != 0);
            exp_rdy   = !bru.flush_in && (!exp_valid || bru.ready_in);
            e = exp_valid ? exp_q[0] : '0;
            n_checks++; if (bru.valid_out !== exp_valid) begin n_errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bru.valid_out, exp_valid); end
            n_checks++; if (bru.ready_out !== exp_rdy) begin n_errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, bru.ready_out, exp_rdy); end
            n_checks++; if (bru.mispredict_out !== (exp_valid && e[17] && !bru.flush_in)) begin n_errors++; $display("FAIL rnd_misp cyc %0d got %b exp %b", c, bru.mispredict_out, exp_valid && e[17] && !bru.flush_in); end
            n_checks++; if (bru.lookup_taken_out !== (ref_cnt[lpc % 16] >= 2)) begin n_errors++; $display("FAIL rnd_lookup cyc %0d got %b exp %b", c, bru.lookup_taken_out, ref_cnt[lpc % 16] >= 2); end
            if (exp_valid) begin
                n_checks++; if ({bru.taken_out, bru.next_pc_out} !== e[16:0]) begin n_errors++; $display("FAIL rnd_result cyc %0d got %h exp %h", c, {bru.taken_out, bru.next_pc_out}, e[16:0]); end
                if (bru.flush_in) begin
                    void'(exp_q.pop_front());
                end else if (bru.ready_in) begin
                    void'(exp_q.pop_front());
                    if (e[22]) begin
                        ix = int'(e[21:18]);
                        if (e[16]) ref_cnt[ix] = (ref_cnt[ix] == 3) ? 3 : ref_cnt[ix] + 1;
                        else ref_cnt[ix] = (ref_cnt[ix] == 0) ? 0 : ref_cnt[ix] - 1;
                    end
                end
            end
            if (bru.valid_in && exp_rdy) exp_q.push_back(ref_entry(cond, sgn[0], d1, d2, pc, tgt, pred[0]));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_eq_mispredict();
        test_signed_lt();
        test_back_to_back();
        test_saturation();
        test_flush_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
